fetch_queue: RTL and testbench

- Two-wide instruction queue directly downstream of the fetch stage; it sits between fetch and decode.
- Accepts up to two fetched instructions per cycle, each carrying pc, instr, guesses_branch and prediction.
- Compacts them in program order and presents up to two oldest entries per cycle to decode.
- Decouples decode stalls from fetch; backpressures fetch via fq_stall and clears on pipeline flush.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side bundle for fetch_queue.
// Two-slot arrays keep slot 0 (the older slot) in the low bits.
interface fetch_queue_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]                 in_valid;
  logic [1:0][ADDR_WIDTH-1:0] in_pc;
  logic [1:0][31:0]           in_instr;
  logic [1:0]                 in_guesses_branch;
  logic [1:0][ADDR_WIDTH-1:0] in_prediction;
  logic                       flush;
  logic                       dec_ready;
  logic                       fq_stall;
  logic [1:0]                 out_valid;
  logic [1:0][ADDR_WIDTH-1:0] out_pc;
  logic [1:0][31:0]           out_instr;
  logic [1:0]                 out_guesses_branch;
  logic [1:0][ADDR_WIDTH-1:0] out_prediction;
  logic [CW-1:0]              count;

  modport master (
    output in_valid, in_pc, in_instr, in_guesses_branch, in_prediction, flush, dec_ready,
    input  fq_stall, out_valid, out_pc, out_instr, out_guesses_branch, out_prediction, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_guesses_branch, in_prediction, flush, dec_ready,
    output fq_stall, out_valid, out_pc, out_instr, out_guesses_branch, out_prediction, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Circular buffer: compacting two-slot enqueue, head/head+1 combinational read.
module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.slave  fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  gb;
    logic [ADDR_WIDTH-1:0] pred;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    enq, deq, out_valid;
  logic          accept;
  entry_t [1:0]  in_ent;

  // Stall depends only on registered occupancy, so a same-cycle pop cannot release it.
  assign fq.fq_stall  = (CW'(DEPTH) - count_q) < CW'(2);
  assign out_valid    = {count_q >= CW'(2), count_q >= CW'(1)};
  assign fq.out_valid = out_valid;
  assign fq.count     = count_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      entry_t rd;
      rd = mem_q[head_q + PW'(i)];
      fq.out_pc[i]             = rd.pc;
      fq.out_instr[i]          = rd.instr;
      fq.out_guesses_branch[i] = rd.gb;
      fq.out_prediction[i]     = rd.pred;
      in_ent[i] = '{pc: fq.in_pc[i], instr: fq.in_instr[i],
                    gb: fq.in_guesses_branch[i], pred: fq.in_prediction[i]};
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    accept  = !fq.fq_stall && !fq.flush;
    enq     = accept ? ({1'b0, fq.in_valid[0]} + {1'b0, fq.in_valid[1]}) : 2'd0;
    deq     = (fq.dec_ready && !fq.flush) ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;
    // A lone slot-1 instruction lands at tail, keeping the buffer dense.
    if (accept) begin
      if (fq.in_valid[0]) mem_d[tail_q] = in_ent[0];
      if (fq.in_valid[1]) mem_d[tail_q + PW'(fq.in_valid[0])] = in_ent[1];
    end
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq);
      tail_d  = tail_q + PW'(enq);
      count_d = count_q - CW'(deq) + CW'(enq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  // Low bits of count equal tail-head; at full both are zero/equal.
  a_count_ptrs: assert property (@(posedge clk) disable iff (reset)
    count_q[PW-1:0] == PW'(tail_q - head_q));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/stall, compaction, overlap, wrap, flush.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.DEPTH(8), .ADDR_WIDTH(32)) fq ();

  fetch_queue #(.DEPTH(8), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // instr/flag/prediction are derived from pc so the bench can predict them.
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic dr, input logic fl);
    fq.in_valid             = v;
    fq.in_pc[0]             = pc0;
    fq.in_pc[1]             = pc1;
    fq.in_instr[0]          = pc0 ^ 32'hA5A5_0000;
    fq.in_instr[1]          = pc1 ^ 32'hA5A5_0000;
    fq.in_guesses_branch[0] = pc0[2];
    fq.in_guesses_branch[1] = pc1[2];
    fq.in_prediction[0]     = pc0 + 32'h40;
    fq.in_prediction[1]     = pc1 + 32'h40;
    fq.dec_ready            = dr;
    fq.flush                = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] opc();
    return {fq.out_pc[1], fq.out_pc[0]};
  endfunction

  initial begin
    reset = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("rst_count", 64'(fq.count), 64'd0);
    chk("rst_valid", 64'(fq.out_valid), 64'd0);
    chk("rst_stall", 64'(fq.fq_stall), 64'd0);
    chk("rst_pc", opc(), 64'd0);

    // Two-slot enqueue, decode stalled
    drive(2'b11, 32'h100, 32'h104, 1'b0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t1_count", 64'(fq.count), 64'd2);
    chk("t1_valid", 64'(fq.out_valid), 64'h3);
    chk("t1_pc", opc(), {32'h104, 32'h100});
    chk("t1_instr", {fq.out_instr[1], fq.out_instr[0]}, {32'hA5A5_0104, 32'hA5A5_0100});
    chk("t1_stall", 64'(fq.fq_stall), 64'd0);

    // Reset with live data clears storage
    do_reset();
    chk("rst2_count", 64'(fq.count), 64'd0);
    chk("rst2_pc", opc(), 64'd0);
    chk("rst2_instr", {fq.out_instr[1], fq.out_instr[0]}, 64'd0);

    // Fill: stall rises once fewer than two entries are free
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k), 1'b0, 1'b0);
      tick();
      chk("fill_count", 64'(fq.count), 64'(2 * (k + 1)));
      chk("fill_stall", 64'(fq.fq_stall), (k == 3) ? 64'd1 : 64'd0);
    end
    drive(2'b11, 32'h900, 32'h904, 1'b0, 1'b0);
    tick();
    chk("full_drop_count", 64'(fq.count), 64'd8);
    chk("full_hold_pc", opc(), {32'h104, 32'h100});
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain_count", 64'(fq.count), 64'd6);
    chk("drain_stall", 64'(fq.fq_stall), 64'd0);
    chk("drain_pc", opc(), {32'h10C, 32'h108});

    // Simultaneous enqueue and dequeue at count 3
    do_reset();
    drive(2'b11, 32'h300, 32'h304, 1'b0, 1'b0);
    tick();
    drive(2'b01, 32'h308, 32'h0, 1'b0, 1'b0);
    tick();
    chk("ovl_pre_count", 64'(fq.count), 64'd3);
    drive(2'b11, 32'h30C, 32'h310, 1'b1, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("ovl_count", 64'(fq.count), 64'd3);
    chk("ovl_pc", opc(), {32'h30C, 32'h308});

    // Compaction of lone slot-1 then slot-0
    do_reset();
    drive(2'b10, 32'hDEAD_0000, 32'h208, 1'b0, 1'b0);
    tick();
    drive(2'b01, 32'h20C, 32'hBEEF_0000, 1'b0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("cmp_count", 64'(fq.count), 64'd2);
    chk("cmp_pc", opc(), {32'h20C, 32'h208});
    chk("cmp_gb", 64'(fq.out_guesses_branch), 64'b10);
    chk("cmp_pred", {fq.out_prediction[1], fq.out_prediction[0]}, {32'h24C, 32'h248});

    // Single-slot streaming across index 7->0, decode always ready
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 32'h210 + 32'(4 * k), 32'h0, 1'b1, 1'b0);
      tick();
      chk("wrap_pc", 64'(fq.out_pc[0]), 64'(32'h210 + 32'(4 * k)));
      chk("wrap_count", 64'(fq.count), 64'd1);
    end
    // head=3, tail=4: push until slot1 is written at index 0
    drive(2'b01, 32'h600, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h604, 32'h608, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h60C, 32'h610, 1'b0, 1'b0);
    tick();
    chk("wr_wrap_count", 64'(fq.count), 64'd6);
    chk("wr_wrap_pc", opc(), {32'h600, 32'h234});
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("rd_mid_pc", opc(), {32'h608, 32'h604});
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rd_wrap_pc", opc(), {32'h610, 32'h60C});
    chk("rd_wrap_count", 64'(fq.count), 64'd2);

    // Flush at count 5 with same-cycle inputs and dequeue
    do_reset();
    drive(2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h508, 32'h50C, 1'b0, 1'b0);
    tick();
    drive(2'b01, 32'h510, 32'h0, 1'b0, 1'b0);
    tick();
    chk("fl_pre_count", 64'(fq.count), 64'd5);
    drive(2'b11, 32'h800, 32'h804, 1'b1, 1'b1);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fl_count", 64'(fq.count), 64'd0);
    chk("fl_valid", 64'(fq.out_valid), 64'd0);
    chk("fl_stall", 64'(fq.fq_stall), 64'd0);
    chk("fl_storage_kept", opc(), {32'h504, 32'h500});
    drive(2'b11, 32'h700, 32'h704, 1'b0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("post_fl_count", 64'(fq.count), 64'd2);
    chk("post_fl_pc", opc(), {32'h704, 32'h700});

    // Flush and reset together: reset wins, storage cleared
    drive(2'b11, 32'h900, 32'h904, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rstfl_count", 64'(fq.count), 64'd0);
    chk("rstfl_pc", opc(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
